rd_width_unpack: RTL and testbench
==================================

RD_WIDTH_UNPACK -- requirements
Module: rd_width_unpack

Interface
REQ-001 SHALL have parameter IN_W, default 32, meaning width of one FIFO read word.
REQ-002 SHALL have parameter OUT_W, default 8, meaning width of one output beat; IN_W SHALL be an integer multiple (RATIO = IN_W/OUT_W, power of 2, at least 2) of OUT_W.
REQ-003 SHALL have parameter MSB_FIRST, default 0, meaning beat order: 0 emits bits [OUT_W-1:0] first, 1 emits the top slice first.
REQ-004 SHALL have port clk_rd, input, 1, the read-domain clock; one clock only.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port fifo_empty, input, 1, meaning the FIFO holds no word.
REQ-007 SHALL have port fifo_rd_req, output, 1, meaning pop one word from the FIFO this cycle.
REQ-008 SHALL have port fifo_rdata, input, IN_W, meaning the popped word, valid exactly one cycle after fifo_rd_req.
REQ-009 SHALL have port out_data, output, OUT_W, meaning the current beat.
REQ-010 SHALL have port out_valid, output, 1, meaning out_data is valid.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer accepts the beat.
REQ-012 SHALL have port out_last, output, 1, meaning the current beat is the final slice of its word.
REQ-013 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH and SEND.
REQ-015 In IDLE: fifo_rd_req = !fifo_empty; when asserted, next state is FETCH.
REQ-016 In FETCH (exactly one cycle): hold <= fifo_rdata, beat counter cnt <= 0; next state SEND; fifo_rd_req = 0.
REQ-017 In SEND: out_valid = 1; handshake = out_valid && out_ready; non-final handshake does cnt <= cnt+1.
REQ-018 On the final handshake (cnt == RATIO-1) in SEND: fifo_rd_req = !fifo_empty in the same cycle; next state is FETCH if asserted, else IDLE.
REQ-019 fifo_rd_req SHALL never assert while fifo_empty = 1, in FETCH, or while rst = 1.
REQ-020 out_data SHALL equal slice cnt of hold (MSB_FIRST=0) or slice RATIO-1-cnt (MSB_FIRST=1), with slice k = hold[k*OUT_W +: OUT_W].
REQ-021 out_data and out_last SHALL remain stable while out_valid && !out_ready (no beat dropped or repeated).
REQ-022 out_last = out_valid && (cnt == RATIO-1).
REQ-023 Latency: first beat valid 2 cycles after fifo_rd_req; sustained throughput is RATIO beats per RATIO+1 cycles with the FIFO non-empty and out_ready held high.
REQ-024 out_valid = 0 in IDLE and FETCH; busy = 1 in FETCH and SEND.
REQ-025 cnt SHALL be clog2(RATIO) bits wide and wrap to 0 only via FETCH load.
REQ-026 fifo_empty changes during SEND SHALL have no effect until the final handshake.

Reset
REQ-027 While rst = 1 at a clk_rd edge: state <= IDLE, cnt <= 0, hold <= 0.
REQ-028 Reset outputs: out_valid 0, out_last 0, busy 0, fifo_rd_req 0, out_data 0.
REQ-029 Reset during FETCH or SEND SHALL discard the held or in-flight word with no further beat emitted; the FIFO word is lost by design.
REQ-030 First fifo_rd_req after reset deassertion SHALL be no earlier than the first cycle with rst = 0.

Structure
REQ-031 State encoding and default IN_W/OUT_W constants SHALL live in the shared package width_trans_pkg, reused by the write-side packer.
REQ-032 No sub-module is required; slice selection SHALL be an internal indexed mux.
REQ-033 Target size is 120-250 lines of RTL; no memories and no clock-domain logic.

Verification
REQ-034 FIFO holds 32'hDDCCBBAA, out_ready=1 -> fifo_rd_req 1 cycle, beats AA,BB,CC,DD on cycles 2-5, out_last on DD, then IDLE.
REQ-035 Same word with MSB_FIRST=1 -> beats DD,CC,BB,AA.
REQ-036 Two words queued, out_ready=1 -> second fifo_rd_req coincident with first DD handshake; 8 beats in 10 cycles.
REQ-037 out_ready low for 3 cycles on beat BB -> BB held stable, no fifo_rd_req, no duplicate, sequence intact.
REQ-038 fifo_empty=1 throughout -> fifo_rd_req, out_valid and busy stay 0.
REQ-039 rst pulsed after beat BB -> out_valid 0 next cycle, state IDLE, next word restarts at slice 0.

Source files
------------

// File: rtl/width_trans_pkg.sv
// Shared constants for the width-translation pair: the write-side packer and the
// read-side unpacker. Holds the FSM state encoding and the default word/beat widths.
package width_trans_pkg;

    // Default FIFO word width and default narrow beat width
    localparam int unsigned DEF_IN_W  = 32;
    localparam int unsigned DEF_OUT_W = 8;

    // Sequencer state encoding, kept as plain constants for legacy tools
    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_FETCH = 2'd1;
    localparam logic [ST_W-1:0] ST_SEND  = 2'd2;

endpackage

// File: rtl/rd_width_unpack.sv
// rd_width_unpack: pops wide words from a FIFO and emits them as a sequence of
// narrow beats over a valid/ready stream.
// Ports:
//   clk_rd       read-domain clock
//   rst          synchronous active-high reset
//   fifo_empty   FIFO holds no word
//   fifo_rd_req  pop one word this cycle (data returns on fifo_rdata next cycle)
//   fifo_rdata   popped word, IN_W bits
//   out_data     current beat, OUT_W bits
//   out_valid    out_data is valid
//   out_ready    consumer accepts the beat
//   out_last     current beat is the final slice of its word
//   busy         sequencer is not idle
module rd_width_unpack
    import width_trans_pkg::*;
#(
    parameter int unsigned IN_W      = DEF_IN_W,
    parameter int unsigned OUT_W     = DEF_OUT_W,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk_rd,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_rd_req,
    input  logic [IN_W-1:0]  fifo_rdata,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned RATIO = IN_W / OUT_W;
    localparam int unsigned CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    // Reject widths that do not split into a power-of-two number (>= 2) of beats
    if ((RATIO < 2) || (RATIO * OUT_W != IN_W) || ((RATIO & (RATIO - 1)) != 0)) begin : g_bad_params
        $error("rd_width_unpack: IN_W must be a power-of-two multiple (>=2) of OUT_W");
    end

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [IN_W-1:0]  hold;
    logic [CNT_W-1:0] sel;
    logic [OUT_W-1:0] slices [RATIO];

    // State register, beat counter and held word
    always_ff @(posedge clk_rd) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_FETCH) begin
                hold <= fifo_rdata;
                cnt  <= '0;
            end else if ((state == ST_SEND) && out_ready && (cnt != CNT_LAST)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Next state and FIFO pop; the final handshake pops the next word in the same cycle
    always_comb begin
        state_nxt   = state;
        fifo_rd_req = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd_req = 1'b1;
                    state_nxt   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready && (cnt == CNT_LAST)) begin
                    if (!fifo_empty) begin
                        fifo_rd_req = 1'b1;
                        state_nxt   = ST_FETCH;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Never pop while reset is held; the popped word would be dropped
        if (rst) begin
            fifo_rd_req = 1'b0;
        end
    end

    // Split the held word into beat-sized slices, slice k = hold[k*OUT_W +: OUT_W]
    for (genvar k = 0; k < RATIO; k++) begin : g_slice
        assign slices[k] = hold[k*OUT_W +: OUT_W];
    end

    // Beat order: counter walks up from slice 0, or down from the top slice
    assign sel       = MSB_FIRST ? (CNT_LAST - cnt) : cnt;
    assign out_valid = (state == ST_SEND);
    assign out_data  = out_valid ? slices[sel] : '0;
    assign out_last  = out_valid && (cnt == CNT_LAST);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_rd_width_unpack.sv
// Directed bench for rd_width_unpack: an LSB-first and an MSB-first instance share
// the same FIFO model and stimulus; every step checks against hand-derived values.
module tb_rd_width_unpack;

    logic        clk_rd = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;
    logic        out_ready;

    logic        fifo_rd_req, out_valid, out_last, busy;
    logic [7:0]  out_data;
    logic        fifo_rd_req_m, out_valid_m, out_last_m, busy_m;
    logic [7:0]  out_data_m;

    logic [31:0] fifo_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk_rd = ~clk_rd;

    rd_width_unpack #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_rd      (clk_rd),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_rd_req (fifo_rd_req),
        .fifo_rdata  (fifo_rdata),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy)
    );

    rd_width_unpack #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk_rd      (clk_rd),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_rd_req (fifo_rd_req_m),
        .fifo_rdata  (fifo_rdata),
        .out_data    (out_data_m),
        .out_valid   (out_valid_m),
        .out_ready   (out_ready),
        .out_last    (out_last_m),
        .busy        (busy_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; a pop requested this cycle returns its word on fifo_rdata next cycle
    task automatic tick();
        logic pop;
        #1;
        pop = fifo_rd_req;
        @(negedge clk_rd);
        if (pop) begin
            if (fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
            else                   fifo_rdata = 32'hDEAD_BEEF;
            fifo_empty = (fifo_q.size() == 0);
        end
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
        #1;
    endtask

    // Check one SEND beat of word w at position k, then let it hand-shake
    task automatic beat(input logic [31:0] w, input int k, input logic exp_req);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = w[k*8 +: 8];
        hi = w[(3-k)*8 +: 8];
        chk($sformatf("valid[%0d]", k), 32'(out_valid), 32'd1);
        chk($sformatf("data_lsb[%0d]", k), 32'(out_data), 32'(lo));
        chk($sformatf("data_msb[%0d]", k), 32'(out_data_m), 32'(hi));
        chk($sformatf("last[%0d]", k), 32'(out_last), (k == 3) ? 32'd1 : 32'd0);
        chk($sformatf("last_msb[%0d]", k), 32'(out_last_m), (k == 3) ? 32'd1 : 32'd0);
        chk($sformatf("busy[%0d]", k), 32'(busy), 32'd1);
        chk($sformatf("rd_req[%0d]", k), 32'(fifo_rd_req), 32'(exp_req));
        tick();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rd_req"}, 32'(fifo_rd_req), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        out_ready  = 1'b1;
        fifo_empty = 1'b1;
        fifo_rdata = 32'h0;
        tick();
        tick();

        // Reset state, with a word already waiting: no pop while reset is held
        push(32'hDDCC_BBAA);
        chk_idle("reset");
        chk("reset_data", 32'(out_data), 32'h0);
        chk("reset_data_msb", 32'(out_data_m), 32'h0);

        // Single word: pop, FETCH, four beats, back to IDLE
        rst = 1'b0;
        #1;
        chk("w1_rd_req", 32'(fifo_rd_req), 32'd1);
        chk("w1_idle_busy", 32'(busy), 32'd0);
        tick();
        chk("w1_fetch_rd_req", 32'(fifo_rd_req), 32'd0);
        chk("w1_fetch_busy", 32'(busy), 32'd1);
        chk("w1_fetch_valid", 32'(out_valid), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) beat(32'hDDCC_BBAA, k, 1'b0);
        chk_idle("w1_done");

        // Empty FIFO throughout: nothing moves
        for (int i = 0; i < 4; i++) begin
            chk_idle("empty");
            tick();
        end

        // Two words back to back: second pop on the first word's final handshake
        push(32'h4433_2211);
        push(32'h8877_6655);
        chk("b2b_rd_req", 32'(fifo_rd_req), 32'd1);
        tick();
        chk("b2b_fetch1_valid", 32'(out_valid), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) beat(32'h4433_2211, k, (k == 3));
        chk("b2b_fetch2_valid", 32'(out_valid), 32'd0);
        chk("b2b_fetch2_busy", 32'(busy), 32'd1);
        chk("b2b_fetch2_rd_req", 32'(fifo_rd_req), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) beat(32'h8877_6655, k, 1'b0);
        chk_idle("b2b_done");

        // Back-pressure on beat BB; a word arriving mid-SEND must not be popped early
        push(32'hDDCC_BBAA);
        tick();
        tick();
        beat(32'hDDCC_BBAA, 0, 1'b0);
        out_ready = 1'b0;
        push(32'h1122_3344);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'hBB);
            chk("stall_data_msb", 32'(out_data_m), 32'hCC);
            chk("stall_last", 32'(out_last), 32'd0);
            chk("stall_rd_req", 32'(fifo_rd_req), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        for (int k = 1; k < 4; k++) beat(32'hDDCC_BBAA, k, (k == 3));
        chk("stall_fetch_valid", 32'(out_valid), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) beat(32'h1122_3344, k, 1'b0);
        chk_idle("stall_done");

        // Reset after beat BB: in-flight word dropped, next word starts at slice 0
        push(32'hCAFE_F00D);
        tick();
        tick();
        beat(32'hCAFE_F00D, 0, 1'b0);
        beat(32'hCAFE_F00D, 1, 1'b0);
        push(32'h0403_0201);
        rst = 1'b1;
        #1;
        chk("rst_mid_rd_req", 32'(fifo_rd_req), 32'd0);
        tick();
        chk_idle("rst_mid");
        chk("rst_mid_data", 32'(out_data), 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_rel_rd_req", 32'(fifo_rd_req), 32'd1);
        tick();
        tick();
        for (int k = 0; k < 4; k++) beat(32'h0403_0201, k, 1'b0);
        chk_idle("rst_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
